// File: rtl/control_unit_mc.sv
// Decode/control unit: registered EX control word, with an optional multi-cycle
// M-extension stall FSM enabled by defining RV32M_EN (default build: M-ops illegal).
module control_unit_mc #(
  parameter int ALU_CTRL_W = 4,
  parameter int MUL_LAT    = 3,
  parameter int DIV_LAT    = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0]            funct7,
  input  logic [2:0]            funct3,
  input  logic [6:0]            opcode,
  input  logic                  valid_ID,
  input  logic                  stall_in,
  input  logic                  flush_in,
  output logic                  stall_ID,
  output logic                  valid_EX,
  output logic                  illegal_EX,
  output logic                  reg_write_EX,
  output logic                  mem_write_EX,
  output logic                  uncond_jump_EX,
  output logic                  meet_branch_EX,
  output logic                  pc_jal_sel_EX,
  output logic                  alu_sel_1_EX,
  output logic [1:0]            result_sel_EX,
  output logic [1:0]            alu_sel_0_EX,
  output logic [ALU_CTRL_W-1:0] alu_ctrl_EX
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_CAL_I  = 7'b0010011;
  localparam logic [6:0] OP_CAL_R  = 7'b0110011;

`ifdef RV32M_EN
  localparam bit M_EN = 1'b1;
`else
  localparam bit M_EN = 1'b0;
`endif

  typedef struct packed {
    logic                  valid;
    logic                  illegal;
    logic                  reg_write;
    logic                  mem_write;
    logic                  uncond_jump;
    logic                  meet_branch;
    logic                  pc_jal_sel;
    logic                  alu_sel_1;
    logic [1:0]            result_sel;
    logic [1:0]            alu_sel_0;
    logic [ALU_CTRL_W-1:0] alu_ctrl;
  } ex_t;

  ex_t  dec;
  ex_t  ex_d;
  ex_t  ex_q;
  logic is_mop;
  logic legal;

  // funct7[5] picks SUB only for register ops, SRA/SRAI for both forms.
  function automatic logic [ALU_CTRL_W-1:0] alu_op(input logic [2:0] f3, input logic alt,
                                                   input logic reg_op, input logic mop);
    logic [ALU_CTRL_W-1:0] r;
    if (mop) begin
      r = f3[2] ? ALU_CTRL_W'(11) : ALU_CTRL_W'(10);
    end else begin
      case (f3)
        3'd0:    r = (reg_op && alt) ? ALU_CTRL_W'(1) : ALU_CTRL_W'(0);
        3'd1:    r = ALU_CTRL_W'(2);
        3'd2:    r = ALU_CTRL_W'(3);
        3'd3:    r = ALU_CTRL_W'(4);
        3'd4:    r = ALU_CTRL_W'(5);
        3'd5:    r = alt ? ALU_CTRL_W'(7) : ALU_CTRL_W'(6);
        3'd6:    r = ALU_CTRL_W'(8);
        default: r = ALU_CTRL_W'(9);
      endcase
    end
    return r;
  endfunction

  assign is_mop = (opcode == OP_CAL_R) && (funct7 == 7'b0000001);

  always_comb begin
    dec       = '0;
    dec.valid = 1'b1;
    legal     = 1'b0;
    case (opcode)
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
      OP_LOAD, OP_STORE, OP_CAL_I, OP_CAL_R: legal = 1'b1;
      default:                               legal = 1'b0;
    endcase
    if (is_mop && !M_EN) legal = 1'b0;
    dec.illegal = !legal;
    // Illegal instructions carry an all-zero control word besides valid/illegal.
    if (legal) begin
      dec.reg_write   = !((opcode == OP_BRANCH) || (opcode == OP_STORE));
      dec.mem_write   = (opcode == OP_STORE);
      dec.uncond_jump = (opcode == OP_JAL) || (opcode == OP_JALR);
      dec.pc_jal_sel  = (opcode == OP_JALR);
      dec.meet_branch = (opcode == OP_BRANCH);
      dec.alu_sel_1   = (opcode != OP_CAL_R);
      if ((opcode == OP_AUIPC) || (opcode == OP_JAL) || (opcode == OP_BRANCH))
        dec.alu_sel_0 = 2'd1;
      else if (opcode == OP_LUI)
        dec.alu_sel_0 = 2'd2;
      if (opcode == OP_LOAD)
        dec.result_sel = 2'd1;
      else if ((opcode == OP_JAL) || (opcode == OP_JALR))
        dec.result_sel = 2'd2;
      if ((opcode == OP_CAL_R) || (opcode == OP_CAL_I))
        dec.alu_ctrl = alu_op(funct3, funct7[5], opcode == OP_CAL_R, is_mop);
    end
  end

`ifdef RV32M_EN
  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] lat_m1;

  assign lat_m1   = funct3[2] ? CNT_W'(DIV_LAT - 1) : CNT_W'(MUL_LAT - 1);
  assign stall_ID = ((state_q == IDLE) && valid_ID && is_mop) ||
                    ((state_q == BUSY) && (cnt_q != '0));

  // The cnt==0 BUSY cycle releases the stall so EX loads the held M-op.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (flush_in) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (!stall_in) begin
      case (state_q)
        IDLE: if (valid_ID && is_mop) begin
          state_d = BUSY;
          cnt_d   = lat_m1;
        end
        BUSY: if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
              else             state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
`else
  assign stall_ID = 1'b0;
`endif

  always_comb begin
    ex_d = ex_q;
    if (flush_in) begin
      ex_d = '0;
    end else if (!stall_in) begin
      if (stall_ID || !valid_ID) ex_d = '0;
      else                       ex_d = dec;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ex_q <= '0;
    else     ex_q <= ex_d;
  end

  assign valid_EX       = ex_q.valid;
  assign illegal_EX     = ex_q.illegal;
  assign reg_write_EX   = ex_q.reg_write;
  assign mem_write_EX   = ex_q.mem_write;
  assign uncond_jump_EX = ex_q.uncond_jump;
  assign meet_branch_EX = ex_q.meet_branch;
  assign pc_jal_sel_EX  = ex_q.pc_jal_sel;
  assign alu_sel_1_EX   = ex_q.alu_sel_1;
  assign result_sel_EX  = ex_q.result_sel;
  assign alu_sel_0_EX   = ex_q.alu_sel_0;
  assign alu_ctrl_EX    = ex_q.alu_ctrl;

endmodule

// File: tb/tb_control_unit_mc.sv
// Self-checking bench for control_unit_mc: directed decode/stall scenarios plus a
// randomized pipeline run against a behavioural bubble-counting reference model.
module tb_control_unit_mc;
  localparam int MUL_LAT = 3;
  localparam int DIV_LAT = 32;
`ifdef RV32M_EN
  localparam bit M_EN = 1'b1;
`else
  localparam bit M_EN = 1'b0;
`endif

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_CAL_I  = 7'b0010011;
  localparam logic [6:0] OP_CAL_R  = 7'b0110011;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] funct7 = '0;
  logic [2:0] funct3 = '0;
  logic [6:0] opcode = '0;
  logic       valid_ID = 1'b0;
  logic       stall_in = 1'b0;
  logic       flush_in = 1'b0;
  logic       stall_ID, valid_EX, illegal_EX, reg_write_EX, mem_write_EX;
  logic       uncond_jump_EX, meet_branch_EX, pc_jal_sel_EX, alu_sel_1_EX;
  logic [1:0] result_sel_EX, alu_sel_0_EX;
  logic [3:0] alu_ctrl_EX;

  control_unit_mc #(.ALU_CTRL_W(4), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .rst(rst), .funct7(funct7), .funct3(funct3), .opcode(opcode),
    .valid_ID(valid_ID), .stall_in(stall_in), .flush_in(flush_in), .stall_ID(stall_ID),
    .valid_EX(valid_EX), .illegal_EX(illegal_EX), .reg_write_EX(reg_write_EX),
    .mem_write_EX(mem_write_EX), .uncond_jump_EX(uncond_jump_EX),
    .meet_branch_EX(meet_branch_EX), .pc_jal_sel_EX(pc_jal_sel_EX),
    .alu_sel_1_EX(alu_sel_1_EX), .result_sel_EX(result_sel_EX),
    .alu_sel_0_EX(alu_sel_0_EX), .alu_ctrl_EX(alu_ctrl_EX)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       valid, illegal, rw, mw, uj, mb, pjs, as1;
    logic [1:0] rs, as0;
    logic [3:0] ac;
  } ex_t;

  ex_t  exp_ex = '0;
  ex_t  obs;
  logic exp_stall, obs_stall;
  bit   m_active = 1'b0;
  int   m_bubbles = 0;
  int   m_lat = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  function automatic ex_t mk(input logic rw, mw, uj, mb, pjs, as1,
                             input logic [1:0] rs, as0, input logic [3:0] ac);
    ex_t e;
    e = '{valid: 1'b1, illegal: 1'b0, rw: rw, mw: mw, uj: uj, mb: mb, pjs: pjs,
          as1: as1, rs: rs, as0: as0, ac: ac};
    return e;
  endfunction

  function automatic ex_t decode(input logic [6:0] f7, input logic [2:0] f3, input logic [6:0] op);
    ex_t e;
    bit  legal, mop;
    int  alu_tab[8] = '{0, 2, 3, 4, 5, 6, 8, 9};
    int  a;
    e = '0;
    e.valid = 1'b1;
    legal = op inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE,
                       OP_CAL_I, OP_CAL_R};
    mop = (op == OP_CAL_R) && (f7 == 7'b0000001);
    if (mop && !M_EN) legal = 1'b0;
    if (!legal) begin
      e.illegal = 1'b1;
      return e;
    end
    e.rw  = !(op == OP_BRANCH || op == OP_STORE);
    e.mw  = (op == OP_STORE);
    e.uj  = (op == OP_JAL || op == OP_JALR);
    e.pjs = (op == OP_JALR);
    e.mb  = (op == OP_BRANCH);
    e.as1 = (op != OP_CAL_R);
    e.as0 = (op == OP_AUIPC || op == OP_JAL || op == OP_BRANCH) ? 2'd1 : (op == OP_LUI) ? 2'd2 : 2'd0;
    e.rs  = (op == OP_LOAD) ? 2'd1 : (op == OP_JAL || op == OP_JALR) ? 2'd2 : 2'd0;
    a = 0;
    if (op == OP_CAL_R || op == OP_CAL_I) begin
      if (mop) a = f3[2] ? 11 : 10;
      else begin
        a = alu_tab[f3];
        if (f3 == 3'd0 && op == OP_CAL_R && f7[5]) a = 1;
        if (f3 == 3'd5 && f7[5]) a = 7;
      end
    end
    e.ac = 4'(a);
    return e;
  endfunction

  // Reference: an M-op owes LAT bubbles (stall_in cycles not counted), then loads.
  task automatic mdl_step();
    bit mop;
    mop = M_EN && valid_ID && (opcode == OP_CAL_R) && (funct7 == 7'b0000001);
    exp_stall = M_EN && ((m_active && m_bubbles < m_lat) || (!m_active && mop));
    if (rst || flush_in) begin
      exp_ex = '0;
      m_active = 1'b0;
    end else if (stall_in) begin
      exp_ex = exp_ex;
    end else if (exp_stall) begin
      exp_ex = '0;
      if (!m_active) begin
        m_active = 1'b1;
        m_lat = funct3[2] ? DIV_LAT : MUL_LAT;
        m_bubbles = 1;
      end else m_bubbles++;
    end else begin
      m_active = 1'b0;
      exp_ex = valid_ID ? decode(funct7, funct3, opcode) : '0;
    end
  endtask

  task automatic tick();
    mdl_step();
    @(negedge clk);
    obs_stall = stall_ID;
    @(posedge clk);
    #1;
    obs = {valid_EX, illegal_EX, reg_write_EX, mem_write_EX, uncond_jump_EX, meet_branch_EX,
           pc_jal_sel_EX, alu_sel_1_EX, result_sel_EX, alu_sel_0_EX, alu_ctrl_EX};
  endtask

  task automatic set_instr(input logic [6:0] f7, input logic [2:0] f3, input logic [6:0] op,
                           input logic v);
    funct7 = f7; funct3 = f3; opcode = op; valid_ID = v;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_instr(7'h00, 3'd0, OP_CAL_R, 1'b1);
    tick();
    tick();
    n_checks++; if (obs !== '0) $display("FAIL reset_ex got %h want 0", obs); else n_pass++;
    n_checks++; if (obs_stall !== 1'b0) $display("FAIL reset_stall got %b want 0", obs_stall); else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_decode();
    logic [6:0] t_f7[12] = '{7'h00, 7'h20, 7'h20, 7'h20, 7'h20, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};
    logic [2:0] t_f3[12] = '{3'd0, 3'd0, 3'd5, 3'd5, 3'd0, 3'd3, 3'd7, 3'd2, 3'd2, 3'd0, 3'd0, 3'd1};
    logic [6:0] t_op[12] = '{OP_CAL_R, OP_CAL_R, OP_CAL_I, OP_CAL_R, OP_CAL_I, OP_CAL_R, OP_CAL_I,
                             OP_STORE, OP_LOAD, OP_LUI, OP_AUIPC, OP_BRANCH};
    ex_t        t_want[12];
    t_want[0]  = mk(1, 0, 0, 0, 0, 0, 2'd0, 2'd0, 4'd0);
    t_want[1]  = mk(1, 0, 0, 0, 0, 0, 2'd0, 2'd0, 4'd1);
    t_want[2]  = mk(1, 0, 0, 0, 0, 1, 2'd0, 2'd0, 4'd7);
    t_want[3]  = mk(1, 0, 0, 0, 0, 0, 2'd0, 2'd0, 4'd7);
    t_want[4]  = mk(1, 0, 0, 0, 0, 1, 2'd0, 2'd0, 4'd0);
    t_want[5]  = mk(1, 0, 0, 0, 0, 0, 2'd0, 2'd0, 4'd4);
    t_want[6]  = mk(1, 0, 0, 0, 0, 1, 2'd0, 2'd0, 4'd9);
    t_want[7]  = mk(0, 1, 0, 0, 0, 1, 2'd0, 2'd0, 4'd0);
    t_want[8]  = mk(1, 0, 0, 0, 0, 1, 2'd1, 2'd0, 4'd0);
    t_want[9]  = mk(1, 0, 0, 0, 0, 1, 2'd0, 2'd2, 4'd0);
    t_want[10] = mk(1, 0, 0, 0, 0, 1, 2'd0, 2'd1, 4'd0);
    t_want[11] = mk(0, 0, 0, 1, 0, 1, 2'd0, 2'd1, 4'd0);
    // Plain ADD: every listed field explicitly.
    set_instr(7'h00, 3'd0, OP_CAL_R, 1'b1);
    tick();
    n_checks++; if (obs_stall !== 1'b0) $display("FAIL add_stall got %b want 0", obs_stall); else n_pass++;
    n_checks++; if ({obs.valid, obs.rw, obs.as1, obs.ac} !== 7'b1_1_0_0000)
      $display("FAIL add_fields got v%b rw%b as1%b ac%0d want v1 rw1 as1=0 ac0", obs.valid, obs.rw, obs.as1, obs.ac);
    else n_pass++;
    set_instr(7'h00, 3'd0, OP_JALR, 1'b1);
    tick();
    n_checks++; if ({obs.uj, obs.pjs, obs.rs, obs.as0, obs.as1} !== 7'b1_1_10_00_1)
      $display("FAIL jalr_fields got uj%b pjs%b rs%0d as0%0d as1%b want 1 1 2 0 1", obs.uj, obs.pjs, obs.rs, obs.as0, obs.as1);
    else n_pass++;
    set_instr(7'h00, 3'd0, OP_JAL, 1'b1);
    tick();
    n_checks++; if (obs !== mk(1, 0, 1, 0, 0, 1, 2'd2, 2'd1, 4'd0))
      $display("FAIL jal_word got %h want %h", obs, mk(1, 0, 1, 0, 0, 1, 2'd2, 2'd1, 4'd0));
    else n_pass++;
    set_instr(7'h00, 3'd0, 7'b1111111, 1'b1);
    tick();
    n_checks++; if ({obs.valid, obs.illegal, obs.rw, obs.mw, obs.uj, obs.mb} !== 6'b110000)
      $display("FAIL illegal_fields got v%b il%b rw%b mw%b uj%b mb%b want 1 1 0 0 0 0",
               obs.valid, obs.illegal, obs.rw, obs.mw, obs.uj, obs.mb);
    else n_pass++;
    for (int i = 0; i < 12; i++) begin
      set_instr(t_f7[i], t_f3[i], t_op[i], 1'b1);
      tick();
      n_checks++; if (obs !== t_want[i]) $display("FAIL decode_%0d got %h want %h", i, obs, t_want[i]); else n_pass++;
    end
    valid_ID = 1'b0;
    tick();
    n_checks++; if (obs !== '0) $display("FAIL no_valid_bubble got %h want 0", obs); else n_pass++;
  endtask

  task automatic test_stall();
    set_instr(7'h00, 3'd0, OP_CAL_R, 1'b1);
    tick();
    set_instr(7'h00, 3'd0, OP_JALR, 1'b1);
    stall_in = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++; if (obs !== mk(1, 0, 0, 0, 0, 0, 2'd0, 2'd0, 4'd0))
        $display("FAIL stall_hold_%0d got %h want ADD word", i, obs);
      else n_pass++;
    end
    flush_in = 1'b1;
    tick();
    n_checks++; if (obs !== '0) $display("FAIL flush_over_stall got %h want 0", obs); else n_pass++;
    flush_in = 1'b0;
    stall_in = 1'b0;
    valid_ID = 1'b0;
    tick();
  endtask

  task automatic test_mop();
`ifdef RV32M_EN
    // MUL: three bubbles with stall_ID up, then the MUL word.
    set_instr(7'h01, 3'd0, OP_CAL_R, 1'b1);
    for (int i = 0; i < MUL_LAT; i++) begin
      tick();
      n_checks++; if ({obs_stall, obs.valid} !== 2'b10)
        $display("FAIL mul_bubble_%0d got stall%b valid%b want stall1 valid0", i, obs_stall, obs.valid);
      else n_pass++;
    end
    tick();
    n_checks++; if ({obs_stall, obs.valid, obs.ac} !== 6'b0_1_1010)
      $display("FAIL mul_load got stall%b valid%b ac%0d want 0 1 10", obs_stall, obs.valid, obs.ac);
    else n_pass++;
    // stall_in held 4 cycles after the first bubble does not add bubbles.
    set_instr(7'h01, 3'd1, OP_CAL_R, 1'b1);
    tick();
    stall_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++; if ({obs_stall, obs.valid} !== 2'b10)
        $display("FAIL mul_frozen_%0d got stall%b valid%b want 1 0", i, obs_stall, obs.valid);
      else n_pass++;
    end
    stall_in = 1'b0;
    for (int i = 0; i < MUL_LAT - 1; i++) begin
      tick();
      n_checks++; if ({obs_stall, obs.valid} !== 2'b10)
        $display("FAIL mul_resume_%0d got stall%b valid%b want 1 0", i, obs_stall, obs.valid);
      else n_pass++;
    end
    tick();
    n_checks++; if ({obs.valid, obs.ac} !== 5'b1_1010)
      $display("FAIL mul_after_freeze got valid%b ac%0d want 1 10", obs.valid, obs.ac);
    else n_pass++;
    // DIV killed by flush at the fifth bubble.
    set_instr(7'h01, 3'd4, OP_CAL_R, 1'b1);
    for (int i = 0; i < 4; i++) tick();
    n_checks++; if (obs_stall !== 1'b1) $display("FAIL div_stalling got %b want 1", obs_stall); else n_pass++;
    flush_in = 1'b1;
    tick();
    n_checks++; if (obs !== '0) $display("FAIL div_flush_ex got %h want 0", obs); else n_pass++;
    flush_in = 1'b0;
    valid_ID = 1'b0;
    tick();
    n_checks++; if ({obs_stall, obs.valid} !== 2'b00)
      $display("FAIL div_after_flush got stall%b valid%b want 0 0", obs_stall, obs.valid);
    else n_pass++;
    // Reset while BUSY abandons the M-op.
    set_instr(7'h01, 3'd0, OP_CAL_R, 1'b1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    valid_ID = 1'b0;
    tick();
    n_checks++; if ({obs_stall, obs.valid} !== 2'b00)
      $display("FAIL rst_busy got stall%b valid%b want 0 0", obs_stall, obs.valid);
    else n_pass++;
`else
    set_instr(7'h01, 3'd0, OP_CAL_R, 1'b1);
    tick();
    n_checks++; if ({obs_stall, obs.valid, obs.illegal, obs.rw} !== 4'b0110)
      $display("FAIL mul_disabled got stall%b v%b il%b rw%b want 0 1 1 0", obs_stall, obs.valid, obs.illegal, obs.rw);
    else n_pass++;
    valid_ID = 1'b0;
    tick();
`endif
  endtask

  task automatic new_instr();
    logic [6:0] ops[9] = '{OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_CAL_I, OP_CAL_R};
    logic [6:0] f7s[4] = '{7'h00, 7'h20, 7'h01, 7'h00};
    int k;
    k = $urandom_range(0, 11);
    opcode = (k < 9) ? ops[k] : (k == 11) ? 7'($urandom) : OP_CAL_R;
    k = $urandom_range(0, 3);
    funct7 = (k == 3) ? 7'($urandom) : f7s[k];
    funct3 = 3'($urandom);
    valid_ID = ($urandom_range(0, 9) < 8);
  endtask

  task automatic test_random();
    ex_t msk;
    bit  adv;
    new_instr();
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 63) == 0);
      flush_in = ($urandom_range(0, 15) == 0);
      stall_in = ($urandom_range(0, 4) == 0);
      tick();
      msk = '1;
      if (exp_ex.illegal) msk = '{valid: 1'b1, illegal: 1'b1, rw: 1'b1, mw: 1'b1, uj: 1'b1, mb: 1'b1, default: '0};
      n_checks++; if (obs_stall !== exp_stall)
        $display("FAIL rand_stall c%0d got %b want %b", c, obs_stall, exp_stall);
      else n_pass++;
      n_checks++; if ((obs & msk) !== (exp_ex & msk))
        $display("FAIL rand_ex c%0d got %h want %h", c, obs, exp_ex);
      else n_pass++;
      adv = rst || flush_in || !(exp_stall || stall_in);
      if (adv) new_instr();
    end
    rst = 1'b0; flush_in = 1'b0; stall_in = 1'b0;
  endtask

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_decode();
    test_stall();
    test_mop();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
